cpu_jtag_ocimem_ctrl: RTL and testbench

- Debug-side on-chip memory controller that consumes the system-clock outputs of the CPU's JTAG debug module: the `jdo` payload and the take-action pulses.
- Executes host-issued address-load, write and read-next commands against a 32-bit debug RAM.
- Returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG capture path.
- Also exposes a CPU-side Avalon-style slave port to the same RAM, with debug accesses taking priority.

---
 rtl/cpu_jtag_ocimem_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_jtag_ocimem_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_jtag_ocimem_ctrl.sv
// Debug-side on-chip memory controller. Runs JTAG host address-load, write
// and read-next commands against a 32-bit debug RAM and shares that RAM with
// a CPU-side slave port. Debug accesses win the single RAM port.
module cpu_jtag_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] mon_areg;
  logic [31:0]       wr_data;
  logic [31:0]       ram_q;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              cpu_rd_pend;

  logic cmd_a, cmd_b, cmd_n;
  logic acc_a, acc_b, acc_n, drop;
  logic dbg_owns, cpu_grant_rd, cpu_grant_wr;
  logic              ram_re, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic unused_ok;
  assign unused_ok = &{1'b0, jdo[37:36], jdo[2:0]};

  // Command decode with a > b > no_action priority, acceptance and FSM next state
  always_comb begin
    cmd_a   = take_action_ocimem_a;
    cmd_b   = !take_action_ocimem_a && take_action_ocimem_b;
    cmd_n   = !take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a;
    // a pure address load never touches the RAM, so it does not need debugack
    acc_a   = cmd_a && (state == IDLE) && (debugack || !jdo[35]);
    acc_b   = cmd_b && (state == IDLE) && debugack;
    acc_n   = cmd_n && (state == IDLE) && debugack;
    drop    = (cmd_a || cmd_b || cmd_n) && !(acc_a || acc_b || acc_n);
    state_n = state;
    case (state)
      IDLE:     if ((acc_a && jdo[35]) || acc_n) state_n = RD_ISSUE;
                else if (acc_b)                  state_n = WR;
      RD_ISSUE: state_n = RD_DATA;
      RD_DATA:  state_n = IDLE;
      WR:       state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // RAM port arbitration: debug owns the port in RD_ISSUE/WR, CPU otherwise
  always_comb begin
    dbg_owns     = (state == RD_ISSUE) || (state == WR);
    cpu_grant_rd = !reset && cpu_read && !cpu_rd_pend && !dbg_owns;
    cpu_grant_wr = !reset && cpu_write && !cpu_read && !dbg_owns;
    ram_re       = (state == RD_ISSUE) || cpu_grant_rd;
    ram_we       = (state == WR) || cpu_grant_wr;
    ram_addr     = dbg_owns ? mon_areg : cpu_address;
    ram_wdata    = (state == WR) ? wr_data : cpu_writedata;
    ram_be       = (state == WR) ? 4'hF : cpu_byteenable;
    if (reset)            cpu_waitrequest = 1'b1;
    else if (cpu_rd_pend) cpu_waitrequest = 1'b0;
    else if (dbg_owns && (cpu_read || cpu_write)) cpu_waitrequest = 1'b1;
    else                  cpu_waitrequest = cpu_read;
  end

  assign cpu_readdata = ram_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Address/data registers, sticky error, RAM output register, CPU read phase
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_areg      <= '0;
      MonDReg       <= '0;
      wr_data       <= '0;
      ram_q         <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      cpu_rd_pend   <= 1'b0;
    end else begin
      if (acc_a)         mon_areg <= jdo[17 +: ADDR_W];
      else if (dbg_owns) mon_areg <= mon_areg + 1'b1;
      if (drop)                monitor_error <= 1'b1;
      else if (acc_a && jdo[34]) monitor_error <= 1'b0;
      if (acc_b)  wr_data <= jdo[34:3];
      if (ram_re) ram_q   <= mem[ram_addr];
      if (state == RD_DATA) MonDReg <= ram_q;
      monitor_ready <= (state_n == IDLE);
      cpu_rd_pend   <= cpu_grant_rd;
    end
  end

  // RAM write port, byte-enabled; a write coincident with reset is suppressed
  always_ff @(posedge clk) begin
    if (!reset && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

endmodule

// File: tb/tb_cpu_jtag_ocimem_ctrl.sv
// Bench for cpu_jtag_ocimem_ctrl: directed debug/CPU sequences, a cycle-count
// model of the controller checked every cycle, and literal spot checks.
module tb_cpu_jtag_ocimem_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_a, take_b, take_n, debugack;
  logic [AW-1:0] cpu_address;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_writedata;
  logic [3:0]    cpu_byteenable;
  logic [31:0]   cpu_readdata, MonDReg;
  logic          cpu_waitrequest, monitor_ready, monitor_error;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_jtag_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
    .take_no_action_ocimem_a(take_n), .debugack(debugack),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] initv(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h3C, b + 8'd1};
  endfunction

  // ---------------- model: counts cycles since a command was accepted -------
  logic [31:0] m_mem [256];
  logic [7:0]  m_addr;
  logic [31:0] m_mon, m_rdval, m_wdat, m_cpu_val;
  logic        m_err, m_cpu_phase, m_started = 1'b0;
  int          m_op, m_age;      // m_op: 0 none, 1 read, 2 write

  always @(posedge clk) begin
    bit idle_pre, owns_pre;
    if (reset) begin
      m_addr = 0; m_mon = 0; m_err = 0; m_op = 0; m_age = 0;
      m_cpu_phase = 0; m_cpu_val = 0; m_started = 1'b1;
    end else begin
      idle_pre = (m_op == 0);
      owns_pre = (m_op != 0) && (m_age == 0);
      // in-flight debug op: RAM touched the cycle after acceptance
      if (m_op == 1) begin
        if (m_age == 0) begin m_rdval = m_mem[m_addr]; m_addr = m_addr + 8'd1; end
        else begin m_mon = m_rdval; m_op = 0; end
        m_age++;
      end else if (m_op == 2) begin
        m_mem[m_addr] = m_wdat; m_addr = m_addr + 8'd1; m_op = 0;
      end
      // CPU side: stalled whenever the debug op is on the RAM
      if (m_cpu_phase) m_cpu_phase = 0;
      else if (cpu_read && !owns_pre) begin m_cpu_phase = 1; m_cpu_val = m_mem[cpu_address]; end
      if (cpu_write && !cpu_read && !owns_pre)
        for (int b = 0; b < 4; b++)
          if (cpu_byteenable[b]) m_mem[cpu_address][8*b +: 8] = cpu_writedata[8*b +: 8];
      // new commands
      if (take_a) begin
        if (idle_pre && (debugack || !jdo[35])) begin
          m_addr = jdo[17 +: 8];
          if (jdo[34]) m_err = 0;
          if (jdo[35]) begin m_op = 1; m_age = 0; end
        end else m_err = 1;
      end else if (take_b) begin
        if (idle_pre && debugack) begin m_op = 2; m_age = 0; m_wdat = jdo[34:3]; end
        else m_err = 1;
      end else if (take_n) begin
        if (idle_pre && debugack) begin m_op = 1; m_age = 0; end
        else m_err = 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic exp_w;
    if (m_started) begin
      if (reset)            exp_w = 1'b1;
      else if (m_cpu_phase) exp_w = 1'b0;
      else if ((m_op != 0) && (m_age == 0) && (cpu_read || cpu_write)) exp_w = 1'b1;
      else                  exp_w = cpu_read;
      check("model_ready", 32'(monitor_ready), 32'(m_op == 0));
      check("model_error", 32'(monitor_error), 32'(m_err));
      check("model_mondreg", MonDReg, m_mon);
      check("model_waitreq", 32'(cpu_waitrequest), 32'(exp_w));
      if (m_cpu_phase) check("model_cpu_rdata", cpu_readdata, m_cpu_val);
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cmd_a(input logic [7:0] a, input logic rd, input logic clr);
    jdo = '0; jdo[35] = rd; jdo[34] = clr; jdo[17 +: 8] = a;
    take_a = 1'b1; cyc(); take_a = 1'b0;
  endtask

  task automatic cmd_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_b = 1'b1; cyc(); take_b = 1'b0;
  endtask

  task automatic cmd_n();
    jdo = '0; take_n = 1'b1; cyc(); take_n = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int stalls);
    logic w; bit ok;
    ok = 0; stalls = 0;
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); w = cpu_waitrequest;
      @(posedge clk); #1;
      if (!w) begin ok = 1; break; end
      stalls++;
    end
    cpu_write = 1'b0;
    if (!ok) check("cpu_wr_timeout", 32'd1, 32'd0);
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
    logic w; bit ok;
    ok = 0; d = 'x;
    cpu_address = a; cpu_read = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); w = cpu_waitrequest; d = cpu_readdata;
      @(posedge clk); #1;
      if (!w) begin ok = 1; break; end
    end
    cpu_read = 1'b0;
    if (!ok) check("cpu_rd_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int st;
    logic [31:0] d;
    reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_n = 0; debugack = 1'b1;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    check("rst_ready", 32'(monitor_ready), 32'd1);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd0);

    for (int i = 0; i < 256; i++) cpu_wr(8'(i), initv(i), 4'hF, st);

    // address load, two writes, then read back through the debug path
    cmd_a(8'h10, 1'b0, 1'b0); cyc();
    cmd_b(32'hDEADBEEF); cyc();
    cmd_b(32'h12345678); cyc();
    cmd_a(8'h10, 1'b1, 1'b0);
    check("rd_busy_t1", 32'(monitor_ready), 32'd0);
    cyc();
    check("rd_mon_t2", MonDReg, 32'h0);
    cyc();
    check("rd_mon_t3", MonDReg, 32'hDEADBEEF);
    check("rd_ready_t3", 32'(monitor_ready), 32'd1);
    cmd_n(); cyc(); cyc();
    check("rd_next", MonDReg, 32'h12345678);
    cpu_rd(8'h11, d); check("cpu_rd_11", d, 32'h12345678);
    cpu_rd(8'h12, d); check("cpu_rd_12", d, 32'h12ED2E13);

    // wrap at the top of the address space
    cmd_a(8'hFF, 1'b0, 1'b0);
    cmd_b(32'hA5A5A5A5); cyc();
    cmd_n(); cyc(); cyc();
    check("wrap_rd0", MonDReg, 32'h00FF3C01);
    cmd_n(); cyc(); cyc();
    check("wrap_rd1", MonDReg, 32'h01FE3D02);
    cpu_rd(8'hFF, d); check("cpu_rd_ff", d, 32'hA5A5A5A5);

    // command while busy is dropped and leaves the address alone
    cmd_n(); cmd_n(); cyc();
    check("drop_err", 32'(monitor_error), 32'd1);
    check("drop_mon", MonDReg, 32'h02FD3E03);
    cyc();
    cmd_n(); cyc(); cyc();
    check("drop_addr", MonDReg, 32'h03FC3F04);
    cmd_a(8'h40, 1'b0, 1'b1);
    check("err_clear", 32'(monitor_error), 32'd0);

    // CPU write colliding with the debug WR cycle at the same address
    cmd_a(8'h20, 1'b0, 1'b0);
    cmd_b(32'h11223344);
    cpu_wr(8'h20, 32'hFFFFFFFF, 4'b0011, st);
    check("coll_stalls", 32'(st), 32'd1);
    cpu_rd(8'h20, d); check("coll_mem", d, 32'h1122FFFF);
    cmd_a(8'h20, 1'b1, 1'b0); cyc(); cyc();
    check("coll_dbg_rd", MonDReg, 32'h1122FFFF);

    // CPU read data cycle overlapping a debug RD_ISSUE
    jdo = '0; take_n = 1'b1; cpu_read = 1'b1; cpu_address = 8'h05;
    cyc(); take_n = 1'b0;
    @(negedge clk);
    check("ovl_waitreq", 32'(cpu_waitrequest), 32'd0);
    check("ovl_rdata", cpu_readdata, 32'h05FA3906);
    @(posedge clk); #1; cpu_read = 1'b0;
    cyc();
    check("ovl_dbg_rd", MonDReg, 32'h21DE1D22);

    // debugack low: read dropped, pure address load still accepted
    debugack = 1'b0;
    cmd_n();
    check("noack_err", 32'(monitor_error), 32'd1);
    check("noack_mon", MonDReg, 32'h21DE1D22);
    cmd_a(8'h30, 1'b0, 1'b0);
    check("noack_ready", 32'(monitor_ready), 32'd1);
    debugack = 1'b1;

    // reset during WR suppresses the write and restores reset values
    cmd_b(32'h0BADF00D);
    reset = 1'b1;
    cyc();
    check("mid_rst_ready", 32'(monitor_ready), 32'd1);
    check("mid_rst_error", 32'(monitor_error), 32'd0);
    check("mid_rst_mon", MonDReg, 32'h0);
    check("mid_rst_wait", 32'(cpu_waitrequest), 32'd1);
    check("mid_rst_rdata", cpu_readdata, 32'h0);
    reset = 1'b0;
    cyc();
    cpu_rd(8'h30, d); check("mid_rst_mem", d, 32'h30CF0C31);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
